// File: rtl/pre_proc_fl.sv
// Signed integer to float-word converter ({sign, expo, normalized mant}) with start/busy/done handshake.
// Define PRE_PROC_FL_LZC_EN to normalize in one cycle with a leading-zero count instead of 1 bit/cycle.
module pre_proc_fl #(
  parameter int NBMANT = 22,
  parameter int NBEXPO = 6,
  parameter int NUBITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     neg,
  input  logic signed [NUBITS-1:0] in,
  output logic                     busy,
  output logic                     done,
  output logic [NBMANT+NBEXPO:0]   out
);

  localparam int OUT_W = NBMANT + NBEXPO + 1;
  localparam logic [OUT_W-1:0] FLOAT_ZERO = {1'b0, 1'b1, {(OUT_W-2){1'b0}}};

  typedef enum logic {IDLE, NORM} state_t;

  state_t            state;
  logic              s_p0;
  logic              zflag_p0;
  logic [NBMANT-1:0] w_p0;

  // Magnitude as unsigned: the most negative input maps to 2^(NUBITS-1) without overflow.
  function automatic logic [NUBITS-1:0] abs_val(input logic signed [NUBITS-1:0] x);
    logic signed [NUBITS-1:0] nx;
    nx = -x;
    abs_val = x[NUBITS-1] ? $unsigned(nx) : $unsigned(x);
  endfunction

`ifdef PRE_PROC_FL_LZC_EN
  function automatic logic [NBEXPO-1:0] lzc(input logic [NBMANT-1:0] v);
    logic found;
    found = 1'b0;
    lzc   = '0;
    for (int i = NBMANT-1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else       lzc  = lzc + NBEXPO'(1);
      end
    end
  endfunction

  logic [NBEXPO-1:0] lz;
  logic [NBEXPO-1:0] lz_neg;
  assign lz     = lzc(w_p0);
  assign lz_neg = -lz;
`else
  logic [NBEXPO-1:0] e_p0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= FLOAT_ZERO;
      s_p0     <= 1'b0;
      zflag_p0 <= 1'b0;
      w_p0     <= '0;
`ifndef PRE_PROC_FL_LZC_EN
      e_p0     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // Operand capture: sign, magnitude and zero flag.
        IDLE: begin
          if (start) begin
            s_p0     <= in[NUBITS-1] ^ neg;
            w_p0     <= NBMANT'(abs_val(in));
            zflag_p0 <= (in == '0);
`ifndef PRE_PROC_FL_LZC_EN
            e_p0     <= '0;
`endif
            busy     <= 1'b1;
            state    <= NORM;
          end
        end
        // Normalization until the mantissa MSB is set; zero bypasses with a forced positive sign.
        NORM: begin
          if (zflag_p0) begin
            out   <= FLOAT_ZERO;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef PRE_PROC_FL_LZC_EN
          end else begin
            out   <= {s_p0, lz_neg, w_p0 << lz};
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
`else
          end else if (w_p0[NBMANT-1]) begin
            out   <= {s_p0, e_p0, w_p0};
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            w_p0 <= w_p0 << 1;
            e_p0 <= e_p0 - NBEXPO'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
